// File: rtl/dff_bank_arbiter.sv
// Round-robin arbiter and write sequencer for one shared WIDTH-bit register.
// Define ARB_TIMEOUT_EN to force release after MAX_HOLD consecutive BUSY cycles.
module dff_bank_arbiter #(
   parameter int WIDTH    = 8,
   parameter int NREQ     = 4,
   parameter int MAX_HOLD = 4
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic [NREQ-1:0]           req_i,
   input  logic [NREQ-1:0]           wr_en_i,
   input  logic [NREQ*WIDTH-1:0]     din_i,
   output logic [NREQ-1:0]           grant_o,
   output logic [$clog2(NREQ)-1:0]   owner_o,
   output logic                      busy_o,
   output logic [WIDTH-1:0]          q_o,
   output logic                      timeout_o
);

   localparam int IW = $clog2(NREQ);
   localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

   if (NREQ < 2 || NREQ > 8 || MAX_HOLD < 1) begin : g_param_check
      $error("dff_bank_arbiter: NREQ must be 2..8 and MAX_HOLD >= 1");
   end

   typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_t;

   state_t                state_q, state_d;
   logic [NREQ-1:0]       grant_q, grant_d;
   logic [IW-1:0]         owner_q, owner_d;
   logic                  busy_q, busy_d;
   logic [WIDTH-1:0]      q_q, q_d;
   logic [WIDTH-1:0]      din_arr [NREQ];
   logic                  sel_found;
   logic [IW-1:0]         sel_idx;
   int                    scan_idx;
`ifdef ARB_TIMEOUT_EN
   logic [HW-1:0]         hold_q, hold_d;
   logic                  timeout_q, timeout_d;
`endif

   for (genvar g = 0; g < NREQ; g++) begin : g_din
      assign din_arr[g] = din_i[g*WIDTH +: WIDTH];
   end

   // owner_q doubles as the rotation pointer: it always holds the last owner,
   // so scanning from owner_q+1 gives the released owner lowest priority.
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = owner_q;
      scan_idx  = 0;
      for (int k = 1; k <= NREQ; k++) begin
         scan_idx = (int'(owner_q) + k) % NREQ;
         if (!sel_found && req_i[scan_idx[IW-1:0]]) begin
            sel_found = 1'b1;
            sel_idx   = scan_idx[IW-1:0];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      owner_d = owner_q;
      busy_d  = busy_q;
      q_d     = q_q;
`ifdef ARB_TIMEOUT_EN
      hold_d    = hold_q;
      timeout_d = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (sel_found) begin
               grant_d = NREQ'(1) << sel_idx;
               owner_d = sel_idx;
               busy_d  = 1'b1;
               state_d = BUSY;
`ifdef ARB_TIMEOUT_EN
               hold_d  = '0;
`endif
            end
         end
         BUSY: begin
            if (!req_i[owner_q]) begin
               grant_d = '0;
               busy_d  = 1'b0;
               state_d = RELEASE;
            end else begin
               if (wr_en_i[owner_q]) q_d = din_arr[owner_q];
`ifdef ARB_TIMEOUT_EN
               if (hold_q == HW'(MAX_HOLD - 1)) begin
                  grant_d   = '0;
                  busy_d    = 1'b0;
                  timeout_d = 1'b1;
                  state_d   = RELEASE;
               end else begin
                  hold_d = hold_q + 1'b1;
               end
`endif
            end
         end
         RELEASE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         grant_q <= '0;
         owner_q <= IW'(NREQ - 1);
         busy_q  <= 1'b0;
         q_q     <= '0;
`ifdef ARB_TIMEOUT_EN
         hold_q    <= '0;
         timeout_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         owner_q <= owner_d;
         busy_q  <= busy_d;
         q_q     <= q_d;
`ifdef ARB_TIMEOUT_EN
         hold_q    <= hold_d;
         timeout_q <= timeout_d;
`endif
      end
   end

   assign grant_o = grant_q;
   assign owner_o = owner_q;
   assign busy_o  = busy_q;
   assign q_o     = q_q;
`ifdef ARB_TIMEOUT_EN
   assign timeout_o = timeout_q;
`else
   assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// Directed and randomized bench for dff_bank_arbiter (WIDTH=8, NREQ=4, MAX_HOLD=4).
module tb_dff_bank_arbiter;

   localparam int WIDTH    = 8;
   localparam int NREQ     = 4;
   localparam int MAX_HOLD = 4;
`ifdef ARB_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic                  clk = 1'b0;
   logic                  rst_n;
   logic [NREQ-1:0]       req;
   logic [NREQ-1:0]       wr;
   logic [NREQ*WIDTH-1:0] din;
   logic [NREQ-1:0]       grant;
   logic [1:0]            owner;
   logic                  busy;
   logic [WIDTH-1:0]      q;
   logic                  timeout;

   int vectors     = 0;
   int miscompares = 0;

   // Reference model: who owns the register, who owned it last, dead-cycle flag.
   int               m_own  = -1;
   int               m_last = NREQ - 1;
   int               m_gap  = 0;
   int               m_hold = 0;
   int               m_to   = 0;
   logic [WIDTH-1:0] m_q    = '0;

   dff_bank_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .MAX_HOLD(MAX_HOLD)) dut (
      .clk_i     (clk),
      .rst_ni    (rst_n),
      .req_i     (req),
      .wr_en_i   (wr),
      .din_i     (din),
      .grant_o   (grant),
      .owner_o   (owner),
      .busy_o    (busy),
      .q_o       (q),
      .timeout_o (timeout)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_step();
      if (!rst_n) begin
         m_own = -1; m_last = NREQ - 1; m_gap = 0; m_hold = 0; m_to = 0; m_q = '0;
      end else begin
         m_to = 0;
         if (m_own >= 0) begin
            if (!req[m_own[1:0]]) begin
               m_own = -1;
               m_gap = 1;
            end else begin
               if (wr[m_own[1:0]]) m_q = WIDTH'(din >> (m_own * WIDTH));
               m_hold++;
               if (TO_EN && m_hold == MAX_HOLD) begin
                  m_own = -1;
                  m_gap = 1;
                  m_to  = 1;
               end
            end
         end else if (m_gap != 0) begin
            m_gap = 0;
         end else begin
            for (int k = 1; k <= NREQ; k++) begin
               int i;
               i = (m_last + k) % NREQ;
               if (m_own < 0 && req[i[1:0]]) begin
                  m_own  = i;
                  m_last = i;
                  m_hold = 0;
               end
            end
         end
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      model_step();
      #1;
      chk("grant", 32'(grant), (m_own >= 0) ? 32'(1 << m_own) : 32'd0);
      chk("owner", 32'(owner), 32'(m_last));
      chk("busy", 32'(busy), 32'(m_own >= 0));
      chk("q", 32'(q), 32'(m_q));
      chk("timeout", 32'(timeout), 32'(m_to));
   endtask

   initial begin
      rst_n = 1'b0; req = '0; wr = '0; din = '0;
      #2;

      // Reset held two edges with every requester active
      req = 4'b1111;
      cycle(); cycle();
      chk("rst_grant", 32'(grant), 32'h0);
      chk("rst_q", 32'(q), 32'h00);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_owner", 32'(owner), 32'h3);
      rst_n = 1'b1;
      cycle();
      chk("first_grant", 32'(grant), 32'b0001);
      req = 4'b0000;
      cycle(); cycle(); cycle();

      // Single write by requester 2
      req = 4'b0100; wr = 4'b0100; din[2*WIDTH +: WIDTH] = 8'hA5;
      cycle();
      chk("sw_grant", 32'(grant), 32'b0100);
      cycle();
      chk("sw_q", 32'(q), 32'hA5);
      req = 4'b0000; wr = 4'b0000;
      cycle();
      chk("sw_drop", 32'(grant), 32'h0);
      cycle();
      chk("sw_release", 32'(busy), 32'h0);
      cycle();

      // Round robin from a fresh pointer
      rst_n = 1'b0; cycle(); rst_n = 1'b1;
      req = 4'b1111; wr = 4'b1111;
      for (int i = 0; i < NREQ; i++) din[i*WIDTH +: WIDTH] = 8'(8'h10 + i);
      for (int i = 0; i <= NREQ; i++) begin
         cycle();
         chk("rr_grant", 32'(grant), 32'(1 << (i % NREQ)));
         if (i < NREQ) begin
            cycle();
            chk("rr_q", 32'(q), 32'(8'h10 + i));
            req[i] = 1'b0;
            cycle();
            chk("rr_gap1", 32'(grant), 32'h0);
            req[i] = 1'b1;
            cycle();
            chk("rr_gap2", 32'(grant), 32'h0);
         end
      end

      // Non-owner isolation with requester 1 owning
      req = 4'b0010; wr = 4'b0000;
      cycle(); cycle(); cycle();
      chk("iso_grant", 32'(grant), 32'b0010);
      wr = 4'b1101;
      din = {8'h33, 8'h22, 8'h3C, 8'h11};
      cycle();
      chk("iso_hold", 32'(q), 32'h13);
      wr = 4'b0010;
      cycle();
      chk("iso_write", 32'(q), 32'h3C);
      req = 4'b0000; wr = 4'b0000;
      cycle(); cycle(); cycle();

      // Hold timeout (or indefinite hold when the feature is absent)
      rst_n = 1'b0; cycle(); rst_n = 1'b1;
      req = 4'b0011; wr = 4'b0001;
      cycle();
      chk("to_grant", 32'(grant), 32'b0001);
`ifdef ARB_TIMEOUT_EN
      for (int d = 1; d <= MAX_HOLD; d++) begin
         din[WIDTH-1:0] = 8'(d);
         cycle();
         chk("to_q", 32'(q), 32'(d));
      end
      chk("to_pulse", 32'(timeout), 32'h1);
      chk("to_grant_low", 32'(grant), 32'h0);
      cycle();
      chk("to_pulse_end", 32'(timeout), 32'h0);
      cycle();
      chk("to_next", 32'(grant), 32'b0010);
`else
      for (int d = 1; d <= MAX_HOLD + 2; d++) begin
         din[WIDTH-1:0] = 8'(d);
         cycle();
         chk("hold_q", 32'(q), 32'(d));
      end
      chk("hold_grant", 32'(grant), 32'b0001);
      chk("hold_no_to", 32'(timeout), 32'h0);
`endif
      req = 4'b0000; wr = 4'b0000;
      cycle(); cycle(); cycle();

      // Reset during an active write
      req = 4'b0100; wr = 4'b0100; din[2*WIDTH +: WIDTH] = 8'h77;
      cycle(); cycle();
      chk("mid_q_before", 32'(q), 32'h77);
      rst_n = 1'b0; din[2*WIDTH +: WIDTH] = 8'h99;
      cycle();
      chk("mid_q", 32'(q), 32'h00);
      chk("mid_grant", 32'(grant), 32'h0);
      rst_n = 1'b1; req = 4'b1111; wr = 4'b0000;
      cycle();
      chk("mid_regrant", 32'(grant), 32'b0001);

      // Randomized traffic
      for (int n = 0; n < 3000; n++) begin
         rst_n = ($urandom_range(0, 99) != 0);
         for (int b = 0; b < NREQ; b++)
            if ($urandom_range(0, 7) == 0) req[b] = ~req[b];
         wr  = 4'($urandom());
         din = $urandom();
         cycle();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/dff_bank_arbiter.md
Name: dff_bank_arbiter

Overview:
- Round-robin arbiter and write sequencer for one shared WIDTH-bit register, a bank of D flip-flops.
- NREQ requesters compete for exclusive write ownership.
- The owner's data is loaded into the bank on its write-enable. Ownership is released on request drop or, optionally, on hold timeout.
- Sits between requesting datapath blocks and the shared storage register in lab-level designs.

Parameters:
WIDTH, 8, data width of shared register
NREQ, 4, number of requesters (2..8)
MAX_HOLD, 4, max consecutive BUSY cycles per grant (used only with ARB_TIMEOUT_EN)

Ports:
Clock  input  1  rising-edge clock
Reset  input  1  synchronous, active-low reset
Req  input  NREQ  per-requester ownership request, level, held while owning
WrEn  input  NREQ  per-requester write strobe; only owner's bit honoured
Din  input  NREQ*WIDTH  packed data; requester i at bits [i*WIDTH +: WIDTH]
Grant  output  NREQ  one-hot registered grant; all-zero when no owner
Owner  output  clog2(NREQ)  index of current/last owner
Busy  output  1  high while Grant nonzero
Q  output  WIDTH  shared register contents
Timeout  output  1  one-cycle pulse on forced release

Behaviour:
- Clock and reset: single clock. Reset is synchronous, active-low: Reset==0 at a rising Clock edge forces:
  - state IDLE, Grant=0, Busy=0, Q=0, Timeout=0, HoldCnt=0
  - Ptr=NREQ-1, so requester 0 has first priority; Owner=NREQ-1
- Reset mid-grant: aborts ownership the same edge. Any in-flight write is discarded.
- States: IDLE, BUSY, RELEASE. All outputs registered.
- IDLE:
  - If any Req bit is set, select the first set bit scanning Ptr+1, Ptr+2, ... modulo NREQ.
  - Next edge: Grant=onehot(sel), Owner=sel, Busy=1, HoldCnt=0, go BUSY.
  - Grant therefore appears one cycle after Req is sampled.
  - If no Req is set, stay IDLE.
- BUSY:
  - Each edge with Req[Owner]=1 and WrEn[Owner]=1: Q <= Din slice of Owner.
  - WrEn from non-owners is ignored. WrEn in IDLE or RELEASE is ignored.
  - HoldCnt increments each BUSY edge, saturating at MAX_HOLD-1.
  - Req[Owner]=0 sampled: no write that edge; Grant=0, Busy=0, Ptr=Owner, go RELEASE.
  - Timeout (feature enabled), Req[Owner]=1 and HoldCnt==MAX_HOLD-1: the final write is honoured that edge if WrEn[Owner]=1. Then Grant=0, Busy=0, Timeout=1 for one cycle, Ptr=Owner, go RELEASE.
- RELEASE: one dead cycle, then IDLE unconditionally. This guarantees a gap between owners so no two Grant bits are ever high together.
- Fairness: the released owner has lowest priority at the next arbitration.
  - A sole requester re-acquires after RELEASE+IDLE, i.e. 2 cycles with Grant low.
- Q holds its value in all states except an honoured owner write.
- Simultaneous requests at arbitration are resolved purely by Ptr rotation.
- Req bits changing while BUSY do not affect the current owner.

Optional Feature:
ARB_TIMEOUT_EN
- Defined: HoldCnt/MAX_HOLD forced release as above; Timeout pulses.
- Undefined: no hold counter logic. Grant is held until Req[Owner] drops. Timeout tied to 0.

Test Plan:
- Reset: Reset=0 for 2 edges with Req=4'b1111 -> Grant=0, Q=8'h00, Busy=0, Owner=3. After release, the first grant is Grant=4'b0001 one cycle later.
- Single write: Req=4'b0100, WrEn[2]=1, Din slice2=8'hA5 -> Grant=4'b0100 next cycle, Q=8'hA5 the following edge. Drop Req -> Grant=0, one RELEASE cycle, then IDLE.
- Round-robin: all Req held, each owner drops Req after 1 write of 8'h10+i -> Grant order 0001,0010,0100,1000,0001. Q follows 8'h10,11,12,13 with a 2-cycle Grant-low gap between owners.
- Non-owner isolation: owner 1 granted, WrEn=4'b1101 with distinct data -> Q unchanged. Then WrEn[1]=1 with Din1=8'h3C -> Q=8'h3C.
- Timeout (ARB_TIMEOUT_EN, MAX_HOLD=4): requester 0 holds Req and WrEn with data 1,2,3,4 -> Q=4 after 4 BUSY edges. Then Timeout=1 one cycle, Grant=0, and pending requester 1 is granted next.
- Reset mid-operation: Reset=0 while BUSY with WrEn asserted -> Q=0, Grant=0 the same edge, no write occurs, next grant goes to requester 0.
